// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared types and constants for the mux/demux family.
//   DATA_W : default data word width
//   N_CH   : number of channels on a demux/mux
//   ch_sel_t / word_t : channel index and data word types
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int DATA_W = 32;
    localparam int N_CH   = 4;

    typedef logic [1:0]        ch_sel_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage : mux_pkg

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
//   One-entry holding register with a valid/ready output handshake.
//   A load always wins over a drain, so a slot that is drained and loaded
//   in the same cycle stays valid and carries the new word.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     load_i     : capture data_i at the next edge
//     data_i     : word to capture
//     ready_i    : consumer accepts the held word this cycle
//     valid_o    : slot holds a word
//     data_o     : held word (stable while valid_o && !ready_i)
// ---------------------------------------------------------------------------
module demux_slot
    import mux_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            // Drain: data is deliberately left in place.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : demux_slot

// File: rtl/demux4_reg.sv
// ---------------------------------------------------------------------------
// demux4_reg
//   Registered 1-to-4 demultiplexer with optional broadcast. Each output
//   channel has its own one-entry holding register and valid/ready pair.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     in_valid/ready : source handshake
//     in_data        : source word
//     in_sel         : destination channel (ignored when in_bcast=1)
//     in_bcast       : deliver to all four channels at once
//     out_valid/ready: per-channel handshakes
//     out_data       : channel i at [i*WIDTH +: WIDTH]
//     busy           : any channel holding a word
// ---------------------------------------------------------------------------
module demux4_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int N_OUT = N_CH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  ch_sel_t                in_sel,
    input  logic                   in_bcast,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   busy
);

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] load;
    logic             accept;

    // A slot is free if empty or being drained this cycle.
    assign free = ~out_valid | out_ready;

    // Broadcast is all-or-nothing; in_valid never feeds in_ready.
    // Held low while in reset so nothing is accepted across the release.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = in_bcast ? (&free) : free[in_sel];
        end
    end

    assign accept = in_valid && in_ready;
    assign busy   = |out_valid;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
            assign load[gi] = accept && (in_bcast || (in_sel == ch_sel_t'(gi)));

            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (load[gi]),
                .data_i  (in_data),
                .ready_i (out_ready[gi]),
                .valid_o (out_valid[gi]),
                .data_o  (out_data[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule : demux4_reg

// File: tb/tb_demux4_reg.sv
module tb_demux4_reg;
    import mux_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    ch_sel_t      in_sel;
    logic         in_bcast;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux4_reg #(.WIDTH(32), .N_OUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         vld;
        logic [1:0]   sel;
        logic         bc;
        logic [31:0]  data;
        logic [3:0]   rdy;
        logic         exp_ir;
        logic [3:0]   exp_ov;   // after the edge
        logic [127:0] exp_od;   // after the edge, {ch3,ch2,ch1,ch0}
    } vec_t;

    vec_t tbl[9];

    // Scoreboard: accepted words per channel, in delivery order.
    word_t q[4][$];

    logic [3:0] exp_free;
    logic       exp_ir;
    logic [3:0] exp_ov;
    logic       p_vld, p_bc;
    logic [1:0] p_sel;
    logic [31:0] p_data;

    initial begin
        // Unicast, stall isolation, drain+load, broadcast stall then release, idle drain.
        tbl[0] = '{1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 4'b1111, 1'b1, 4'b0100,
                   {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}};
        tbl[1] = '{1'b1, 2'd1, 1'b0, 32'h11111111, 4'b1101, 1'b1, 4'b0010,
                   {32'h0, 32'hDEADBEEF, 32'h11111111, 32'h0}};
        tbl[2] = '{1'b1, 2'd1, 1'b0, 32'h22222222, 4'b1101, 1'b0, 4'b0010,
                   {32'h0, 32'hDEADBEEF, 32'h11111111, 32'h0}};
        tbl[3] = '{1'b1, 2'd3, 1'b0, 32'h00000001, 4'b1101, 1'b1, 4'b1010,
                   {32'h1, 32'hDEADBEEF, 32'h11111111, 32'h0}};
        tbl[4] = '{1'b1, 2'd0, 1'b0, 32'h0000000A, 4'b0101, 1'b1, 4'b1011,
                   {32'h1, 32'hDEADBEEF, 32'h11111111, 32'hA}};
        tbl[5] = '{1'b1, 2'd0, 1'b0, 32'h0000000B, 4'b0101, 1'b1, 4'b1011,
                   {32'h1, 32'hDEADBEEF, 32'h11111111, 32'hB}};
        tbl[6] = '{1'b1, 2'd0, 1'b1, 32'h12345678, 4'b0111, 1'b0, 4'b1000,
                   {32'h1, 32'hDEADBEEF, 32'h11111111, 32'hB}};
        tbl[7] = '{1'b1, 2'd0, 1'b1, 32'h12345678, 4'b1000, 1'b1, 4'b1111,
                   {4{32'h12345678}}};
        tbl[8] = '{1'b0, 2'd0, 1'b0, 32'h0,        4'b1111, 1'b1, 4'b0000,
                   {4{32'h12345678}}};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
        in_bcast = 1'b0; out_ready = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---- Reset mid-transfer with out_valid=0101 ----
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hAAAA0000;
        @(negedge clk);
        in_sel = 2'd2; in_data = 32'hBBBB2222;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_reset_valid", 128'(out_valid), 128'(4'b0101));
        chk("pre_reset_busy", 128'(busy), 128'(1'b1));
        #2;
        in_valid = 1'b1; in_sel = 2'd1;
        rst_n = 1'b0;
        #1;
        chk("reset_valid", 128'(out_valid), 128'(4'b0000));
        chk("reset_data", out_data, 128'h0);
        chk("reset_in_ready", 128'(in_ready), 128'(1'b0));
        chk("reset_busy", 128'(busy), 128'(1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Table-driven directed vectors ----
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = tbl[i].vld; in_sel = tbl[i].sel; in_bcast = tbl[i].bc;
            in_data = tbl[i].data; out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].exp_ov));
            chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].exp_od);
        end

        // ---- Randomized run against scoreboard (all slots empty here) ----
        p_vld = 1'b0; p_bc = 1'b0; p_sel = '0; p_data = '0;
        exp_ir = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            // Source must hold its request while stalled.
            if (!(p_vld && !exp_ir)) begin
                p_vld  = ($urandom_range(0, 3) != 0);
                p_bc   = ($urandom_range(0, 7) == 0);
                p_sel  = 2'($urandom_range(0, 3));
                p_data = $urandom;
            end
            in_valid = p_vld; in_bcast = p_bc; in_sel = p_sel; in_data = p_data;
            out_ready = 4'($urandom);
            #1;
            for (int k = 0; k < 4; k++) begin
                exp_ov[k]   = (q[k].size() != 0);
                exp_free[k] = !exp_ov[k] || out_ready[k];
            end
            exp_ir = p_bc ? (&exp_free) : exp_free[p_sel];
            chk("rnd_in_ready", 128'(in_ready), 128'(exp_ir));
            chk("rnd_out_valid", 128'(out_valid), 128'(exp_ov));
            chk("rnd_busy", 128'(busy), 128'(|exp_ov));
            for (int k = 0; k < 4; k++) begin
                if (exp_ov[k]) begin
                    chk($sformatf("rnd_data_ch%0d", k), 128'(out_data[k*32 +: 32]), 128'(q[k][0]));
                    if (out_ready[k]) void'(q[k].pop_front());
                end
                if (p_vld && exp_ir && (p_bc || p_sel == 2'(k))) q[k].push_back(p_data);
            end
        end

        // Drain everything and confirm nothing was left undelivered.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 4'hF;
        @(negedge clk);
        chk("final_empty", 128'(out_valid), 128'(4'b0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux4_reg
